// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared constants for the RV32IM pipeline stage registers
package cpu_pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam int IF_ID_W = 64;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with two-entry skid and flush
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              pop;

  // All outputs come from registered state, so in_ready never sees out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign level     = state_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops everything, including a same-cycle accept.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
  import cpu_pipe_pkg::*;

  localparam int          W    = IF_ID_W;
  localparam logic [W-1:0] RVAL = {32'h0, RV_NOP};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   level;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_last;

  pipe_stage_reg #(.DATA_W(W), .RESET_VAL(RVAL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, then compare.
  task automatic step(input logic r, input logic iv, input logic [W-1:0] d,
                      input logic fl, input logic ordy, input bit probe);
    bit m_acc, m_pop;
    logic ir_before;
    rst = r; in_valid = iv; in_data = d; flush = fl; out_ready = ordy;
    m_acc = iv && (mq.size() < 2);
    m_pop = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (!r || fl) begin
      mq.delete();
      m_last = RVAL;
    end else begin
      if (m_pop) m_last = mq.pop_front();
      if (m_acc) mq.push_back(d);
    end
    #1;
    check("out_valid", W'(out_valid), W'(mq.size() > 0));
    check("level",     W'(level),     W'(mq.size()));
    check("in_ready",  W'(in_ready),  W'(mq.size() < 2));
    check("out_data",  out_data,      (mq.size() > 0) ? mq[0] : m_last);
    if (probe) begin
      ir_before = in_ready;
      out_ready = ~out_ready;
      #1;
      check("in_ready_comb", W'(in_ready), W'(ir_before));
      out_ready = ~out_ready;
    end
  endtask

  initial begin
    mq.delete();
    m_last = RVAL;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    // reset held with a pending input
    step(1'b0, 1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    check("reset_data", out_data, RVAL);
    step(1'b1, 1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
    check("first_accept", out_data, 64'h1);

    // streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, W'(i), 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // stall and skid: 5 then 6 into skid, 7 held upstream
    step(1'b1, 1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h7, 1'b0, 1'b0, 1'b1);
    check("skid_level", W'(level), W'(2));
    step(1'b1, 1'b1, 64'h7, 1'b0, 1'b1, 1'b0);
    check("release_main", out_data, 64'h6);
    step(1'b1, 1'b1, 64'h7, 1'b0, 1'b1, 1'b0);
    check("release_skid", out_data, 64'h7);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // flush while full drops the same-cycle 9
    step(1'b1, 1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h9, 1'b1, 1'b0, 1'b0);
    check("flush_data", out_data, RVAL);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // reset and flush together with an accept
    step(1'b1, 1'b1, 64'h21, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'h22, 1'b1, 1'b0, 1'b0);
    check("rst_flush_level", W'(level), W'(0));
    // flush and pop together
    step(1'b1, 1'b1, 64'h31, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h32, 1'b1, 1'b1, 1'b0);
    check("flush_pop_valid", W'(out_valid), W'(0));

    for (int c = 0; c < 10000; c++) begin
      step(($urandom_range(0, 499) != 0),
           ($urandom_range(0, 3) != 0),
           {$urandom, $urandom},
           ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, a two-entry skid buffer and synchronous flush. It replaces the fixed-width, always-loading inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the RV32IM pipeline. Each instance carries one stage's payload, for example {pc, instr} for IF/ID. It adds back-pressure (stall), bubble insertion on flush, and defined reset values instead of X.

## Interface
Parameters:
- DATA_W, 64, payload width in bits (IF/ID: {pc[31:0], instr[31:0]})
- RESET_VAL, {DATA_W{1'b0}}, value driven on out_data after reset or flush (IF/ID: {32'h0, 32'h00000013} = NOP)

Ports:
- clk  input  1  stage clock; all state updates on posedge
- rst  input  1  synchronous reset, active-low (sampled on posedge clk; 0 = reset)
- in_valid  input  1  upstream presents in_data
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready
- in_data  input  DATA_W  upstream payload
- flush  input  1  discard all held entries (branch/jump redirect, trap)
- out_valid  output  1  out_data is a live instruction (0 = bubble)
- out_ready  input  1  downstream consumes this cycle (0 = stall)
- out_data  output  DATA_W  payload to next stage
- level  output  2  occupancy: 0, 1 or 2

## Operation
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main register (drives out_data) plus one skid register, each with its own valid bit. State is EMPTY (level 0), ONE (main valid) or FULL (main and skid valid).
- EMPTY: accept → ONE, main ← in_data. Otherwise stay.
- ONE:
  - accept & pop → ONE, main ← in_data.
  - accept & !pop → FULL, skid ← in_data.
  - !accept & pop → EMPTY.
  - Otherwise stay.
- FULL: in_ready = 0, so no accept is possible. pop → ONE, main ← skid. Otherwise stay.
- in_ready = (state != FULL), computed from registered state only.
- FIFO order is preserved. No payload is duplicated or dropped except by flush.
- On the transition to EMPTY, out_data holds its last value and out_valid = 0. Consumers must qualify out_data with out_valid.
- Flush: the next state is EMPTY, out_data ← RESET_VAL and level ← 0. Flush overrides accept and pop in the same cycle. An in_data accepted in the flush cycle is discarded.
- Reset (rst = 0): same effect as flush. Reset has priority over flush.

## Timing
- Reset values: out_valid = 0, out_data = RESET_VAL, in_ready = 1, level = 0, skid valid = 0.
- Latency: accept in cycle N (EMPTY or ONE with pop) → out_valid/out_data updated at edge N+1.
- Throughput: one transfer per cycle while out_ready = 1.
- Stall: with out_ready = 0, one further input is absorbed into skid. in_ready falls at the following edge.
- Release from FULL: out_ready = 1 pops main at that edge. Skid moves to main, and in_ready = 1 in the next cycle.
- Simultaneous flush and pop: the downstream sees pop complete in that cycle. The state is still EMPTY afterwards.
- rst deasserted mid-stream: the first accept is possible in the cycle rst returns to 1.

## Structure
- Shared package cpu_pipe_pkg holds:
  - state encoding localparams ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2
  - RV_NOP = 32'h00000013
  - payload width constants: IF_ID_W = 64, plus ID_EX_W etc. as stages migrate
- Flat single module, no sub-modules; the skid entry is too small to justify one.
- Target size is roughly 150 lines, with the next-state logic in one always block.

## Test plan
- Reset: hold rst = 0 for 2 cycles with in_valid = 1 and in_data = 64'hA → out_valid = 0, out_data = RESET_VAL, level = 0, in_ready = 1. Release; in_data = 64'h1 accepted → next edge out_valid = 1, out_data = 64'h1.
- Streaming: out_ready = 1, in_valid = 1, push 1..8 on consecutive cycles → out_data = 1..8 on consecutive cycles, level stays 1, in_ready never drops.
- Stall/skid: push 5, 6, 7 with out_ready = 0 from the cycle after 5 arrives.
  - 5 sits in main, 6 goes to skid, level = 2, in_ready = 0, 7 is held upstream.
  - Raise out_ready → pops 5, 6, 7 in order with no loss.
- Flush while FULL: state FULL (main = 5, skid = 6), assert flush with in_valid = 1 and in_data = 9 → next edge out_valid = 0, out_data = RESET_VAL, level = 0. 9 is not delivered.
- Priority: rst = 0 and flush = 1 in the same cycle with accept → reset values result. Flush and pop together → pop counted, state EMPTY.
- Random: constrained-random in_valid/out_ready over 10k cycles against a scoreboard FIFO model, with a 1% flush rate → order preserved, level ≤ 2, and no in_ready dependence on the same-cycle out_ready.
